frac_line_feeder: RTL and testbench

Line streamer that drives the input side of the fractional-search filter. On a start pulse it reads one padded 16-pixel-wide filter block (HEIGHT+TAPS-1 lines) and one 8x8 reference block from two line memories, and emits them line by line. The first TAPS-1 cycles carry filter lines only, to fill the filter window; the remaining HEIGHT lines carry a filter line and its matching reference line together. It sits between the block-fetch memories and the fractional search core.

---
 rtl/frac_line_feeder_pkg.sv | 29 ++
 rtl/frac_line_feeder_if.sv | 50 +++++
 rtl/frac_line_feeder_skid.sv | 43 ++++
 rtl/frac_line_feeder.sv | 185 ++++++++++++++++++
 tb/tb_frac_line_feeder.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/frac_line_feeder_pkg.sv
// Shared types and constants for the fractional-search line path.
// Also imported by the frac search core.
package frac_line_feeder_pkg;

  localparam int PIX_W         = 8;
  localparam int FILT_LINE_PIX = 16;
  localparam int REF_LINE_PIX  = 8;
  localparam int FILT_W        = PIX_W * FILT_LINE_PIX;
  localparam int REF_W         = PIX_W * REF_LINE_PIX;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    BOTH,
    DONE
  } state_t;

  typedef struct packed {
    logic [FILT_W-1:0] pix;
    logic [REF_W-1:0]  rpix;
    logic              rv;
    logic              last;
  } line_t;

  function automatic int fill_lines(input int taps);
    return taps - 1;
  endfunction

endpackage

// File: rtl/frac_line_feeder_if.sv
// Request, line-memory read and line-stream signals of the feeder.
// master = feeder side, slave = memories, requester and core.
interface frac_line_feeder_if #(
  parameter int FILT_AW = 8,
  parameter int REF_AW  = 8
);
  import frac_line_feeder_pkg::*;

  logic               start;
  logic [FILT_AW-1:0] filt_base;
  logic [REF_AW-1:0]  ref_base;
  logic               busy;

  logic               filt_rd_en;
  logic [FILT_AW-1:0] filt_rd_addr;
  logic [FILT_W-1:0]  filt_rd_data;
  logic               ref_rd_en;
  logic [REF_AW-1:0]  ref_rd_addr;
  logic [REF_W-1:0]   ref_rd_data;

  logic [FILT_W-1:0]  filter_pix;
  logic [REF_W-1:0]   ref_pix;
  logic               pix_valid;
  logic               ref_valid;
  logic               last;
  logic               out_ready;

  modport master (
    input  start, filt_base, ref_base,
    input  filt_rd_data, ref_rd_data,
    input  out_ready,
    output busy,
    output filt_rd_en, filt_rd_addr,
    output ref_rd_en, ref_rd_addr,
    output filter_pix, ref_pix,
    output pix_valid, ref_valid, last
  );

  modport slave (
    output start, filt_base, ref_base,
    output filt_rd_data, ref_rd_data,
    output out_ready,
    input  busy,
    input  filt_rd_en, filt_rd_addr,
    input  ref_rd_en, ref_rd_addr,
    input  filter_pix, ref_pix,
    input  pix_valid, ref_valid, last
  );

endinterface

// File: rtl/frac_line_feeder_skid.sv
// One-entry skid buffer holding a returned line while the core stalls.
// Load wins over unload; the feeder never asks for both at once.
module frac_line_skid
  import frac_line_feeder_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  load_i,
  input  logic  unload_i,
  input  line_t data_i,
  output logic  full_o,
  output line_t data_o
);

  logic  full_q, full_d;
  line_t data_q, data_d;

  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (unload_i) begin
      full_d = 1'b0;
    end
    if (load_i) begin
      full_d = 1'b1;
      data_d = data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign full_o = full_q;
  assign data_o = data_q;

endmodule

// File: rtl/frac_line_feeder.sv
// Streams a padded filter block and a reference block line by line.
// Optional blk_count output: define FRAC_LINE_FEEDER_CNT_EN.
module frac_line_feeder
  import frac_line_feeder_pkg::*;
#(
  parameter int HEIGHT  = 8,
  parameter int TAPS    = 8,
  parameter int FILT_AW = 8,
  parameter int REF_AW  = 8
) (
  input  logic clk,
  input  logic reset,
  frac_line_feeder_if.master bus
`ifdef FRAC_LINE_FEEDER_CNT_EN
  ,
  output logic [15:0] blk_count
`endif
);

  localparam int FILL_N = fill_lines(TAPS);
  localparam int LINES  = HEIGHT + FILL_N;
  localparam int NW     = $clog2(LINES + 1);

  localparam logic [NW-1:0] N_END  = NW'(LINES);
  localparam logic [NW-1:0] N_LAST = NW'(LINES - 1);
  localparam logic [NW-1:0] N_FILL = NW'(FILL_N);
  localparam logic [NW-1:0] N_FEND = NW'(FILL_N - 1);

  state_t             state_q, state_d;
  logic [NW-1:0]      n_q, n_d;
  logic [FILT_AW-1:0] fbase_q, fbase_d;
  logic [REF_AW-1:0]  rbase_q, rbase_d;
  logic               infl_q, infl_d;
  logic               infl_rv_q, infl_rv_d;
  logic               infl_last_q, infl_last_d;

  logic               skid_full;
  line_t              skid_line;
  line_t              cur_line;
  line_t              out_line;
  logic               pix_valid;
  logic               fire;
  logic               skid_load;
  logic               skid_unload;
  logic               can_issue;
  logic               issue;
  logic               ref_issue;
  logic [NW-1:0]      rn;

  // Line currently on the memory read ports (read issued last cycle)
  always_comb begin
    cur_line      = '0;
    cur_line.pix  = bus.filt_rd_data;
    cur_line.rpix = infl_rv_q ? bus.ref_rd_data : '0;
    cur_line.rv   = infl_rv_q;
    cur_line.last = infl_last_q;
  end

  always_comb begin
    out_line = '0;
    if (skid_full) begin
      out_line = skid_line;
    end else if (infl_q) begin
      out_line = cur_line;
    end
  end

  assign pix_valid   = skid_full | infl_q;
  assign fire        = pix_valid & bus.out_ready;
  assign skid_load   = infl_q & ~skid_full & ~bus.out_ready;
  assign skid_unload = skid_full & bus.out_ready;

  // Issue only if the presented slot is free by the next edge
  assign can_issue = ~skid_full & (~infl_q | bus.out_ready);
  assign issue     = can_issue &
                     ((state_q == FILL) |
                      ((state_q == BOTH) & (n_q != N_END)));
  assign ref_issue = issue & (state_q == BOTH);
  assign rn        = n_q - N_FILL;

  frac_line_skid u_skid (
    .clk      (clk),
    .reset    (reset),
    .load_i   (skid_load),
    .unload_i (skid_unload),
    .data_i   (cur_line),
    .full_o   (skid_full),
    .data_o   (skid_line)
  );

  always_comb begin
    state_d     = state_q;
    n_d         = n_q;
    fbase_d     = fbase_q;
    rbase_d     = rbase_q;
    infl_d      = issue;
    infl_rv_d   = ref_issue;
    infl_last_d = issue & (n_q == N_LAST);
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          fbase_d = bus.filt_base;
          rbase_d = bus.ref_base;
          n_d     = '0;
          state_d = FILL;
        end
      end
      FILL: begin
        if (issue) begin
          n_d = n_q + NW'(1);
          if (n_q == N_FEND) begin
            state_d = BOTH;
          end
        end
      end
      BOTH: begin
        if (issue) begin
          n_d = n_q + NW'(1);
        end
        if (fire && out_line.last) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      n_q         <= '0;
      fbase_q     <= '0;
      rbase_q     <= '0;
      infl_q      <= 1'b0;
      infl_rv_q   <= 1'b0;
      infl_last_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      fbase_q     <= fbase_d;
      rbase_q     <= rbase_d;
      infl_q      <= infl_d;
      infl_rv_q   <= infl_rv_d;
      infl_last_q <= infl_last_d;
    end
  end

`ifdef FRAC_LINE_FEEDER_CNT_EN
  logic [15:0] blk_cnt_q, blk_cnt_d;

  always_comb begin
    blk_cnt_d = blk_cnt_q;
    if (state_d == DONE && state_q != DONE) begin
      blk_cnt_d = blk_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      blk_cnt_q <= '0;
    end else begin
      blk_cnt_q <= blk_cnt_d;
    end
  end

  assign blk_count = blk_cnt_q;
`endif

  assign bus.busy         = (state_q != IDLE);
  assign bus.filt_rd_en   = issue;
  assign bus.filt_rd_addr = issue ? fbase_q + FILT_AW'(n_q) : '0;
  assign bus.ref_rd_en    = ref_issue;
  assign bus.ref_rd_addr  = ref_issue ? rbase_q + REF_AW'(rn) : '0;
  assign bus.filter_pix   = out_line.pix;
  assign bus.ref_pix      = out_line.rpix;
  assign bus.ref_valid    = out_line.rv;
  assign bus.last         = out_line.last;
  assign bus.pix_valid    = pix_valid;

endmodule

// File: tb/tb_frac_line_feeder.sv
// Scoreboard bench for frac_line_feeder: directed blocks, stalls,
// wrap, ignored start, mid-block reset, optional block counter.
module tb_frac_line_feeder;
  import frac_line_feeder_pkg::*;

  logic clk;
  logic reset;
  int   cyc;
  int   checks;
  int   errors;
  int   last_cyc;

  frac_line_feeder_if #(.FILT_AW(8), .REF_AW(8)) bus ();

`ifdef FRAC_LINE_FEEDER_CNT_EN
  logic [15:0] blk_count;
`endif

  frac_line_feeder #(
    .HEIGHT(8), .TAPS(8), .FILT_AW(8), .REF_AW(8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef FRAC_LINE_FEEDER_CNT_EN
    ,
    .blk_count (blk_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Line memories: each word is its own address, replicated
  always @(posedge clk) begin
    if (bus.filt_rd_en) bus.filt_rd_data <= {16{bus.filt_rd_addr}};
    if (bus.ref_rd_en)  bus.ref_rd_data  <= {8{bus.ref_rd_addr}};
  end

  line_t exp_q[$];
  line_t got;
  line_t exp_l;
  line_t stall_line;
  logic  stall_prev;

  always_comb begin
    got      = '0;
    got.pix  = bus.filter_pix;
    got.rpix = bus.ref_pix;
    got.rv   = bus.ref_valid;
    got.last = bus.last;
  end

  initial stall_prev = 1'b0;

  always @(negedge clk) begin
    if (!reset && bus.pix_valid && bus.out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_line cyc=%0d got filt=%h", cyc, got.pix[7:0]);
      end else begin
        exp_l = exp_q.pop_front();
        if (got !== exp_l) begin
          errors++;
          $display("FAIL line cyc=%0d got f=%h r=%h rv=%b l=%b exp f=%h r=%h rv=%b l=%b",
                   cyc, got.pix[7:0], got.rpix[7:0], got.rv, got.last,
                   exp_l.pix[7:0], exp_l.rpix[7:0], exp_l.rv, exp_l.last);
        end
        if (exp_l.last) last_cyc = cyc;
      end
    end
    if (stall_prev && !reset) begin
      checks++;
      if (!bus.pix_valid || got !== stall_line) begin
        errors++;
        $display("FAIL stall_hold cyc=%0d got v=%b f=%h exp v=1 f=%h",
                 cyc, bus.pix_valid, got.pix[7:0], stall_line.pix[7:0]);
      end
    end
    stall_prev = !reset && bus.pix_valid && !bus.out_ready;
    stall_line = got;
  end

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic push_block(input logic [7:0] fb, input logic [7:0] rb);
    line_t l;
    logic [7:0] a;
    for (int n = 0; n < 15; n++) begin
      l = '0;
      a = fb + 8'(n);
      l.pix = {16{a}};
      if (n >= 7) begin
        a = rb + 8'(n - 7);
        l.rpix = {8{a}};
        l.rv = 1'b1;
      end
      l.last = (n == 14);
      exp_q.push_back(l);
    end
  endtask

  // Start pulse in cycle t; returns 1ns into cycle t+1
  task automatic start_block(input logic [7:0] fb, input logic [7:0] rb,
                             output int t);
    push_block(fb, rb);
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.filt_base = fb;
    bus.ref_base = rb;
    t = cyc;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic finish_block(output int busy_low);
    int i;
    i = 0;
    while (exp_q.size() != 0 && i < 200) begin
      @(negedge clk);
      i++;
    end
    check("drain_timeout", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    i = 0;
    while (bus.busy && i < 20) begin
      @(negedge clk);
      i++;
    end
    check("busy_clear_timeout", 64'(bus.busy), 64'd0);
    busy_low = cyc;
  endtask

  task automatic outs_zero(input string name);
    check(name, 64'({bus.busy, bus.filt_rd_en, bus.ref_rd_en, bus.pix_valid,
                     bus.ref_valid, bus.last, bus.filt_rd_addr, bus.ref_rd_addr,
                     |bus.filter_pix, |bus.ref_pix}), 64'd0);
  endtask

  int t0;
  int tb_low;

  initial begin
    cyc = 0;
    checks = 0;
    errors = 0;
    last_cyc = 0;
    reset = 1'b1;
    bus.start = 1'b0;
    bus.filt_base = '0;
    bus.ref_base = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    outs_zero("reset_outputs");

    // Back-to-back block with latency checks
    start_block(8'h10, 8'h40, t0);
    @(negedge clk);
    check("rd_en_at_t1", 64'({bus.filt_rd_en, bus.pix_valid, bus.busy}), 64'b101);
    check("rd_addr_line0", 64'(bus.filt_rd_addr), 64'h10);
    @(negedge clk);
    check("valid_at_t2", 64'(bus.pix_valid), 64'd1);
    finish_block(tb_low);
    check("last_cycle", 64'(last_cyc - t0), 64'd16);
    check("busy_low_after_last", 64'(tb_low - last_cyc), 64'd2);

    // Backpressure at line 5 (presented in cycle t+7)
    start_block(8'h20, 8'h50, t0);
    repeat (6) @(posedge clk);
    #1 bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 bus.out_ready = 1'b1;
    finish_block(tb_low);
    check("stall_last_cycle", 64'(last_cyc - t0), 64'd20);

    // Filter address wrap-around
    start_block(8'hFA, 8'h80, t0);
    finish_block(tb_low);
    check("wrap_last_cycle", 64'(last_cyc - t0), 64'd16);

    // start while busy at line 4 must be ignored
    start_block(8'h30, 8'h60, t0);
    repeat (5) @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.filt_base = 8'hC0;
    bus.ref_base = 8'hD0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    finish_block(tb_low);
    repeat (20) @(negedge clk);
    check("no_second_block", 64'(bus.busy), 64'd0);

    // Reset during line 9 (presented in cycle t+11)
    start_block(8'h70, 8'h90, t0);
    repeat (10) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_q.delete();
    @(negedge clk);
    outs_zero("reset_abort_outputs");
    repeat (3) @(negedge clk);
    check("reset_abort_idle", 64'({bus.busy, bus.pix_valid}), 64'd0);
    start_block(8'h00, 8'h08, t0);
    finish_block(tb_low);
    check("post_reset_last", 64'(last_cyc - t0), 64'd16);

`ifdef FRAC_LINE_FEEDER_CNT_EN
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    for (int b = 0; b < 3; b++) begin
      start_block(8'h10 + 8'(b), 8'h40, t0);
      finish_block(tb_low);
    end
    check("blk_count_3", 64'(blk_count), 64'd3);
    @(posedge clk);
    force dut.blk_cnt_q = 16'hFFFF;
    @(posedge clk); #1;
    release dut.blk_cnt_q;
    start_block(8'h10, 8'h40, t0);
    finish_block(tb_low);
    check("blk_count_wrap", 64'(blk_count), 64'd0);
`endif

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
